// File: rtl/elelock_pkg.sv
// Shared definitions for the programmable keypad lock: FSM state encodings,
// the "no key" digit code and the one-hot ten-key encoder.
package elelock_pkg;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_SETCODE = 2'd2,
    ST_PENALTY = 2'd3
  } state_t;

  localparam logic [3:0] KEY_NONE = 4'hF;

  // Anything other than exactly one key held (none, or a chord) maps to KEY_NONE.
  function automatic logic [3:0] keyenc(input logic [9:0] tk);
    logic [3:0] d;
    case (tk)
      10'b00_0000_0001: d = 4'd0;
      10'b00_0000_0010: d = 4'd1;
      10'b00_0000_0100: d = 4'd2;
      10'b00_0000_1000: d = 4'd3;
      10'b00_0001_0000: d = 4'd4;
      10'b00_0010_0000: d = 4'd5;
      10'b00_0100_0000: d = 4'd6;
      10'b00_1000_0000: d = 4'd7;
      10'b01_0000_0000: d = 4'd8;
      10'b10_0000_0000: d = 4'd9;
      default:          d = KEY_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/elelock_if.sv
// Keypad-side inputs and actuator/display outputs of the keypad lock.
// The keypad/host side uses master, the lock core uses slave.
interface elelock_if #(
  parameter int NDIGIT = 4
) ();
  logic [9:0]                     tenkey;
  logic                           enter;
  logic                           close;
  logic                           set_code;
  logic                           lock;
  logic                           alarm;
  logic                           prog;
  logic [$clog2(NDIGIT+1)-1:0]    ndig;

  modport master (output tenkey, enter, close, set_code,
                  input  lock, alarm, prog, ndig);
  modport slave  (input  tenkey, enter, close, set_code,
                  output lock, alarm, prog, ndig);
endinterface

// File: rtl/elelock_keyin.sv
// Key edge detection: two-flop history per key input; one strobe per press,
// asserted on the cycle after the key is first seen.
module elelock_keyin
  import elelock_pkg::*;
(
  input  logic       ck,
  input  logic       reset,
  input  logic [9:0] tenkey,
  input  logic       enter,
  output logic       key_stb,
  output logic [3:0] key_val,
  output logic       ent_stb
);

  logic       ke1_r, ke2_r, ee1_r, ee2_r;
  logic [9:0] tk_r;

  // Key level history and digit sample, taken together so the digit matches the strobe.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      ke1_r <= 1'b0;
      ke2_r <= 1'b0;
      ee1_r <= 1'b0;
      ee2_r <= 1'b0;
      tk_r  <= 10'd0;
    end else begin
      ke1_r <= |tenkey;
      ke2_r <= ke1_r;
      ee1_r <= enter;
      ee2_r <= ee1_r;
      tk_r  <= tenkey;
    end
  end

  assign key_val = keyenc(tk_r);
  assign key_stb = ke1_r & ~ke2_r & (key_val != KEY_NONE);
  assign ent_stb = ee1_r & ~ee2_r;

endmodule

// File: rtl/elelock_prog.sv
// Programmable NDIGIT keypad lock: code entry, user code change, failed-attempt
// lockout. Define ELELOCK_AUTO_RELOCK_EN to relock automatically after idle time in OPEN.
module elelock_prog
  import elelock_pkg::*;
#(
  parameter int                  NDIGIT          = 4,
  parameter logic [4*NDIGIT-1:0] DEFAULT_CODE    = 16'h5963,
  parameter int                  MAX_FAIL        = 3,
  parameter int                  PENALTY_CYC     = 1000,
  parameter int                  AUTO_RELOCK_CYC = 5000
) (
  input logic       ck,
  input logic       reset,
  elelock_if.slave  bus
);

  localparam int NW = $clog2(NDIGIT + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int PW = $clog2(PENALTY_CYC + 1);
  localparam logic [NW-1:0] NDIG_FULL  = NW'(NDIGIT);
  localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAIL - 1);
  localparam logic [PW-1:0] PEN_LOAD   = PW'(PENALTY_CYC);
  localparam logic [PW-1:0] TIMER_LAST = PW'(1);

  state_t              state_r;
  logic                lock_r, alarm_r, prog_r;
  logic [4*NDIGIT-1:0] entry_r, secret_r, entry_shift_s;
  logic [NW-1:0]       ndig_r, ndig_inc_s;
  logic [FW-1:0]       fail_r;
  logic [PW-1:0]       timer_r;
  logic                key_stb_s, ent_stb_s, match_s, relock_s;
  logic [3:0]          key_val_s;

  elelock_keyin u_keyin (
    .ck      (ck),
    .reset   (reset),
    .tenkey  (bus.tenkey),
    .enter   (bus.enter),
    .key_stb (key_stb_s),
    .key_val (key_val_s),
    .ent_stb (ent_stb_s)
  );

  // Entry shift (newest digit at LS), saturating digit count and code comparison.
  always_comb begin
    entry_shift_s       = entry_r << 3'd4;
    entry_shift_s[3:0]  = key_val_s;
    ndig_inc_s          = (ndig_r == NDIG_FULL) ? ndig_r : ndig_r + 1'b1;
    match_s             = (ndig_r == NDIG_FULL) && (entry_r == secret_r);
  end

`ifdef ELELOCK_AUTO_RELOCK_EN
  localparam int IW = $clog2(AUTO_RELOCK_CYC + 1);
  logic [IW-1:0] idle_r;

  // Idle timer: held loaded outside OPEN so it starts full on entry, reloaded by any activity.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      idle_r <= '0;
    end else if (state_r != ST_OPEN || key_stb_s || ent_stb_s || bus.set_code) begin
      idle_r <= IW'(AUTO_RELOCK_CYC);
    end else if (idle_r != '0) begin
      idle_r <= idle_r - 1'b1;
    end
  end

  assign relock_s = (state_r == ST_OPEN) && (idle_r == IW'(1));
`else
  assign relock_s = (AUTO_RELOCK_CYC < 0);
`endif

  // Lock FSM with entry/secret/fail/penalty registers; every state change clears the entry.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_r  <= ST_OPEN;
      lock_r   <= 1'b0;
      alarm_r  <= 1'b0;
      prog_r   <= 1'b0;
      entry_r  <= '1;
      ndig_r   <= '0;
      secret_r <= DEFAULT_CODE;
      fail_r   <= '0;
      timer_r  <= '0;
    end else begin
      case (state_r)
        ST_OPEN: begin
          if (bus.close || relock_s) begin
            state_r <= ST_LOCKED;
            lock_r  <= 1'b1;
            entry_r <= '1;
            ndig_r  <= '0;
          end else if (bus.set_code) begin
            state_r <= ST_SETCODE;
            prog_r  <= 1'b1;
            entry_r <= '1;
            ndig_r  <= '0;
          end else if (ent_stb_s) begin
            entry_r <= '1;
            ndig_r  <= '0;
          end else if (key_stb_s) begin
            entry_r <= entry_shift_s;
            ndig_r  <= ndig_inc_s;
          end
        end
        ST_SETCODE: begin
          if (bus.close) begin
            state_r <= ST_LOCKED;
            prog_r  <= 1'b0;
            lock_r  <= 1'b1;
            entry_r <= '1;
            ndig_r  <= '0;
          end else if (ent_stb_s) begin
            if (ndig_r == NDIG_FULL) begin
              secret_r <= entry_r;
              state_r  <= ST_OPEN;
              prog_r   <= 1'b0;
            end
            entry_r <= '1;
            ndig_r  <= '0;
          end else if (key_stb_s) begin
            entry_r <= entry_shift_s;
            ndig_r  <= ndig_inc_s;
          end
        end
        ST_LOCKED: begin
          if (bus.close) begin
            entry_r <= '1;
            ndig_r  <= '0;
          end else if (ent_stb_s) begin
            if (match_s) begin
              state_r <= ST_OPEN;
              lock_r  <= 1'b0;
              fail_r  <= '0;
            end else if (fail_r == FAIL_LAST) begin
              state_r <= ST_PENALTY;
              alarm_r <= 1'b1;
              timer_r <= PEN_LOAD;
              fail_r  <= fail_r + 1'b1;
            end else begin
              fail_r  <= fail_r + 1'b1;
            end
            entry_r <= '1;
            ndig_r  <= '0;
          end else if (key_stb_s) begin
            entry_r <= entry_shift_s;
            ndig_r  <= ndig_inc_s;
          end
        end
        ST_PENALTY: begin
          entry_r <= '1;
          ndig_r  <= '0;
          if (timer_r == TIMER_LAST) begin
            state_r <= ST_LOCKED;
            alarm_r <= 1'b0;
            fail_r  <= '0;
            timer_r <= '0;
          end else begin
            timer_r <= timer_r - 1'b1;
          end
        end
        default: begin
          state_r <= ST_OPEN;
          lock_r  <= 1'b0;
          alarm_r <= 1'b0;
          prog_r  <= 1'b0;
          entry_r <= '1;
          ndig_r  <= '0;
        end
      endcase
    end
  end

  assign bus.lock  = lock_r;
  assign bus.alarm = alarm_r;
  assign bus.prog  = prog_r;
  assign bus.ndig  = ndig_r;

endmodule

// File: tb/tb_elelock_prog.sv
// Self-checking bench for elelock_prog: table of keypad steps with a scoreboard
// queue, plus hand-written sequences for timing, penalty and reset corners.
module tb_elelock_prog;

  localparam int ARC = 30;

  logic ck = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  elelock_if #(.NDIGIT(4)) bus ();

  elelock_prog #(
    .NDIGIT(4), .DEFAULT_CODE(16'h5963), .MAX_FAIL(3),
    .PENALTY_CYC(20), .AUTO_RELOCK_CYC(ARC)
  ) dut (
    .ck(ck), .reset(reset), .bus(bus)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] tk;
    logic       en, cl, sc;
    logic       lk, al, pg;
    int         nd;
  } vec_t;

  typedef struct {
    logic lk, al, pg;
    int   nd;
  } exp_t;

  vec_t vt[$];
  exp_t sbq[$];
  localparam logic [9:0] NOKEY = 10'd0;

  function automatic logic [9:0] kd(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction

  function automatic vec_t mk(input logic [9:0] tk, input logic en, input logic cl, input logic sc,
                              input logic lk, input logic al, input logic pg, input int nd);
    vec_t v;
    v.tk = tk; v.en = en; v.cl = cl; v.sc = sc;
    v.lk = lk; v.al = al; v.pg = pg; v.nd = nd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge once the press has settled.
  task automatic press(input logic [9:0] tk, input logic en, input logic cl, input logic sc);
    bus.tenkey = tk; bus.enter = en; bus.close = cl; bus.set_code = sc;
    repeat (2) @(negedge ck);
    bus.tenkey = NOKEY; bus.enter = 1'b0; bus.close = 1'b0; bus.set_code = 1'b0;
    repeat (3) @(negedge ck);
  endtask

  task automatic code(input int a, input int b, input int c, input int d);
    press(kd(a), 1'b0, 1'b0, 1'b0);
    press(kd(b), 1'b0, 1'b0, 1'b0);
    press(kd(c), 1'b0, 1'b0, 1'b0);
    press(kd(d), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wrong_attempt();
    code(9, 9, 9, 9);
    press(NOKEY, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   t0, t1;
    bit   seen;

    // OPEN -> LOCKED, default code unlocks
    vt.push_back(mk(NOKEY, 0, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(kd(5), 0, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(kd(9), 0, 0, 0, 1, 0, 0, 2));
    vt.push_back(mk(kd(6), 0, 0, 0, 1, 0, 0, 3));
    vt.push_back(mk(kd(3), 0, 0, 0, 1, 0, 0, 4));
    vt.push_back(mk(NOKEY, 1, 0, 0, 0, 0, 0, 0));
    // code change: short ENTER stays in SETCODE, full ENTER stores 1234
    vt.push_back(mk(NOKEY, 0, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(kd(1), 0, 0, 0, 0, 0, 1, 1));
    vt.push_back(mk(kd(2), 0, 0, 0, 0, 0, 1, 2));
    vt.push_back(mk(kd(3), 0, 0, 0, 0, 0, 1, 3));
    vt.push_back(mk(NOKEY, 1, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(kd(1), 0, 0, 0, 0, 0, 1, 1));
    vt.push_back(mk(kd(2), 0, 0, 0, 0, 0, 1, 2));
    vt.push_back(mk(kd(3), 0, 0, 0, 0, 0, 1, 3));
    vt.push_back(mk(kd(4), 0, 0, 0, 0, 0, 1, 4));
    vt.push_back(mk(NOKEY, 1, 0, 0, 0, 0, 0, 0));
    // new code unlocks
    vt.push_back(mk(NOKEY, 0, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(kd(1), 0, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(kd(2), 0, 0, 0, 1, 0, 0, 2));
    vt.push_back(mk(kd(3), 0, 0, 0, 1, 0, 0, 3));
    vt.push_back(mk(kd(4), 0, 0, 0, 1, 0, 0, 4));
    vt.push_back(mk(NOKEY, 1, 0, 0, 0, 0, 0, 0));
    // old code now fails
    vt.push_back(mk(NOKEY, 0, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(kd(5), 0, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(kd(9), 0, 0, 0, 1, 0, 0, 2));
    vt.push_back(mk(kd(6), 0, 0, 0, 1, 0, 0, 3));
    vt.push_back(mk(kd(3), 0, 0, 0, 1, 0, 0, 4));
    vt.push_back(mk(NOKEY, 1, 0, 0, 1, 0, 0, 0));
    // five digits: last four kept, ndig saturates
    vt.push_back(mk(kd(7), 0, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(kd(1), 0, 0, 0, 1, 0, 0, 2));
    vt.push_back(mk(kd(2), 0, 0, 0, 1, 0, 0, 3));
    vt.push_back(mk(kd(3), 0, 0, 0, 1, 0, 0, 4));
    vt.push_back(mk(kd(4), 0, 0, 0, 1, 0, 0, 4));
    vt.push_back(mk(NOKEY, 1, 0, 0, 0, 0, 0, 0));
    // chord ignored, close in LOCKED clears entry
    vt.push_back(mk(NOKEY, 0, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(kd(1), 0, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(10'b0000100001, 0, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(NOKEY, 0, 1, 0, 1, 0, 0, 0));

    bus.tenkey = NOKEY; bus.enter = 1'b0; bus.close = 1'b0; bus.set_code = 1'b0;
    repeat (3) @(negedge ck);
    chk("reset_lock", bus.lock, 1'b0);
    chk("reset_alarm", bus.alarm, 1'b0);
    chk("reset_prog", bus.prog, 1'b0);
    chk("reset_ndig", bus.ndig, 0);
    reset = 1'b0;
    @(negedge ck);

    foreach (vt[i]) begin
      e.lk = vt[i].lk; e.al = vt[i].al; e.pg = vt[i].pg; e.nd = vt[i].nd;
      sbq.push_back(e);
      press(vt[i].tk, vt[i].en, vt[i].cl, vt[i].sc);
      e = sbq.pop_front();
      chk($sformatf("step%0d_lock", i), bus.lock, e.lk);
      chk($sformatf("step%0d_alarm", i), bus.alarm, e.al);
      chk($sformatf("step%0d_prog", i), bus.prog, e.pg);
      chk($sformatf("step%0d_ndig", i), bus.ndig, e.nd);
    end

    // ENTER latency: lock drops on the second edge after ENTER rises
    code(1, 2, 3, 4);
    bus.enter = 1'b1;
    @(posedge ck); #1;
    chk("enter_edge1_lock", bus.lock, 1'b1);
    @(posedge ck); #1;
    chk("enter_edge2_lock", bus.lock, 1'b0);
    @(negedge ck);
    bus.enter = 1'b0;
    repeat (3) @(negedge ck);
    press(NOKEY, 1'b0, 1'b1, 1'b0);

    // two failures, then correct code with close+ENTER together: close wins, no attempt counted
    wrong_attempt();
    wrong_attempt();
    chk("two_fail_alarm", bus.alarm, 1'b0);
    code(1, 2, 3, 4);
    bus.close = 1'b1; bus.enter = 1'b1;
    repeat (3) @(negedge ck);
    bus.close = 1'b0; bus.enter = 1'b0;
    repeat (3) @(negedge ck);
    chk("close_enter_lock", bus.lock, 1'b1);
    chk("close_enter_alarm", bus.alarm, 1'b0);
    chk("close_enter_ndig", bus.ndig, 0);
    code(1, 2, 3, 4);
    press(NOKEY, 1'b1, 1'b0, 1'b0);
    chk("unlock_after_fails", bus.lock, 1'b0);

    // fail count restarted by the unlock; third wrong ENTER enters penalty
    press(NOKEY, 1'b0, 1'b1, 1'b0);
    wrong_attempt();
    wrong_attempt();
    chk("fail_reset_alarm", bus.alarm, 1'b0);
    code(9, 9, 9, 9);
    bus.enter = 1'b1;
    seen = 1'b0;
    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ck); #1;
      if (bus.alarm) begin
        seen = 1'b1;
        t0 = cyc;
        break;
      end
    end
    chk("penalty_entered", seen, 1'b1);
    @(negedge ck);
    bus.enter = 1'b0;
    repeat (3) @(negedge ck);
    press(kd(1), 1'b0, 1'b0, 1'b0);
    chk("penalty_key_ignored", bus.ndig, 0);
    press(NOKEY, 1'b1, 1'b0, 1'b0);
    chk("penalty_enter_alarm", bus.alarm, 1'b1);
    chk("penalty_enter_lock", bus.lock, 1'b1);
    seen = 1'b0;
    t1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge ck); #1;
      if (!bus.alarm) begin
        seen = 1'b1;
        t1 = cyc;
        break;
      end
    end
    chk("penalty_ended", seen, 1'b1);
    chk("penalty_cycles", t1 - t0, 20);
    chk("after_penalty_lock", bus.lock, 1'b1);
    @(negedge ck);

    // reset in the middle of a penalty
    wrong_attempt();
    wrong_attempt();
    wrong_attempt();
    chk("penalty2_alarm", bus.alarm, 1'b1);
    repeat (4) @(negedge ck);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_lock", bus.lock, 1'b0);
    chk("async_reset_alarm", bus.alarm, 1'b0);
    chk("async_reset_prog", bus.prog, 1'b0);
    @(negedge ck);
    reset = 1'b0;
    @(negedge ck);
    press(NOKEY, 1'b0, 1'b1, 1'b0);
    chk("relock_after_reset", bus.lock, 1'b1);
    code(5, 9, 6, 3);
    press(NOKEY, 1'b1, 1'b0, 1'b0);
    chk("default_code_restored", bus.lock, 1'b0);

`ifdef ELELOCK_AUTO_RELOCK_EN
    // OPEN was entered 3 edges before press() returned
    seen = 1'b0;
    t0 = cyc;
    t1 = 0;
    for (int i = 0; i < ARC + 20; i++) begin
      @(posedge ck); #1;
      if (bus.lock) begin
        seen = 1'b1;
        t1 = cyc;
        break;
      end
    end
    chk("auto_relock_seen", seen, 1'b1);
    chk("auto_relock_cycles", t1 - t0, ARC - 3);
`else
    repeat (ARC + 10) @(negedge ck);
    chk("no_auto_relock", bus.lock, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
